// File: rtl/riscv_inst_cache.sv
// Direct-mapped instruction cache with one-cycle hit latency and full-line refill.
// A fetch address is captured on one edge and looked up combinationally in the next cycle.
// On a miss the whole line is fetched word by word from backing memory, starting at word 0.
// The DONE state then serves the requested word.
// Optional build macro ICACHE_STATS_EN adds 32-bit hit/miss lookup counters.
module riscv_inst_cache #(
    parameter int unsigned LINES = 16,
    parameter int unsigned WORDS = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] inst_cache_a_i,
    input  logic        inst_cache_ren_i,
    output logic [31:0] inst_cache_d_o,
    output logic        stall_o,
    input  logic        flush_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_data_i
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_count_o,
    output logic [31:0] miss_count_o
`endif
);

    localparam int unsigned OFF_W   = $clog2(WORDS);
    localparam int unsigned IDX_W   = $clog2(LINES);
    localparam int unsigned TAG_W   = 30 - OFF_W - IDX_W;
    localparam int unsigned TAG_LSB = 2 + OFF_W + IDX_W;

    typedef enum logic [1:0] {StIdle, StRefill, StDone} state_e;

    state_e             state_q;
    logic [31:0]        lookup_addr_q;
    logic               pending_q;
    logic [OFF_W-1:0]   cnt_q;
    logic [LINES-1:0]   valid_q;
    logic               flush_q;
    logic [31:0]        data_q;

    logic [TAG_W-1:0]   tag_mem  [LINES];
    logic [31:0]        data_mem [LINES*WORDS];

    logic [OFF_W-1:0]   offset;
    logic [IDX_W-1:0]   index;
    logic [TAG_W-1:0]   tag;
    logic               hit;
    logic               deliver;
    logic               mem_we;
    logic               ack_last;
    logic [31:0]        rd_word;
    logic               unused_addr;

    assign offset      = lookup_addr_q[OFF_W+1:2];
    assign index       = lookup_addr_q[OFF_W+2 +: IDX_W];
    assign tag         = lookup_addr_q[31:TAG_LSB];
    // Byte-offset bits are always zero for word-aligned fetches.
    assign unused_addr = ^lookup_addr_q[1:0];

    // Lookup, stall and memory-request decode from the captured address and state
    always_comb begin
        hit            = pending_q & valid_q[index] & (tag_mem[index] == tag);
        rd_word        = data_mem[{index, offset}];
        deliver        = ((state_q == StIdle) & hit) | (state_q == StDone);
        stall_o        = ((state_q == StIdle) & pending_q & ~hit) | (state_q == StRefill);
        inst_cache_d_o = deliver ? rd_word : data_q;
        mem_req_o      = (state_q == StRefill);
        mem_addr_o     = mem_req_o ? {tag, index, cnt_q, 2'b00} : 32'h0;
        mem_we         = (state_q == StRefill) & mem_ack_i;
        ack_last       = mem_we & (cnt_q == OFF_W'(WORDS - 1));
    end

    // Line storage; deliberately not reset, validity is tracked by valid_q
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            data_mem[{index, cnt_q}] <= mem_data_i;
        end
        if (ack_last) begin
            tag_mem[index] <= tag;
        end
    end

    // Control FSM, fetch capture, valid bits and last-delivered word
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= StIdle;
            lookup_addr_q <= '0;
            pending_q     <= 1'b0;
            cnt_q         <= '0;
            valid_q       <= '0;
            flush_q       <= 1'b0;
            data_q        <= '0;
        end else begin
            // A new fetch is accepted only when the pipeline is not held.
            if (!stall_o) begin
                if (inst_cache_ren_i) begin
                    lookup_addr_q <= inst_cache_a_i;
                    pending_q     <= 1'b1;
                end else begin
                    pending_q     <= 1'b0;
                end
            end
            if (deliver) begin
                data_q <= rd_word;
            end
            unique case (state_q)
                StIdle: begin
                    if (flush_i) begin
                        valid_q <= '0;
                    end
                    if (pending_q && !hit) begin
                        state_q <= StRefill;
                        cnt_q   <= '0;
                    end
                end
                StRefill: begin
                    // Flush is deferred so the refill in flight still serves its word.
                    if (flush_i) begin
                        flush_q <= 1'b1;
                    end
                    if (mem_ack_i) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (ack_last) begin
                            valid_q[index] <= 1'b1;
                            state_q        <= StDone;
                        end
                    end
                end
                StDone: begin
                    if (flush_i || flush_q) begin
                        valid_q <= '0;
                    end
                    flush_q <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    // One count per lookup evaluated in IDLE with a pending fetch
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (state_q == StIdle && pending_q) begin
            if (hit) begin
                hit_cnt_q  <= hit_cnt_q + 32'd1;
            end else begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_count_o  = hit_cnt_q;
    assign miss_count_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_riscv_inst_cache.sv
// Randomized self-checking bench for riscv_inst_cache.
// The reference is a line-presence table plus a closed-form backing-memory content function.
module tb_riscv_inst_cache;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] inst_cache_a_i = '0;
    logic        inst_cache_ren_i = 1'b0;
    logic [31:0] inst_cache_d_o;
    logic        stall_o;
    logic        flush_i = 1'b0;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i = 1'b0;
    logic [31:0] mem_data_i = '0;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count_o;
    logic [31:0] miss_count_o;
`endif

    riscv_inst_cache #(.LINES(16), .WORDS(4)) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .inst_cache_a_i   (inst_cache_a_i),
        .inst_cache_ren_i (inst_cache_ren_i),
        .inst_cache_d_o   (inst_cache_d_o),
        .stall_o          (stall_o),
        .flush_i          (flush_i),
        .mem_req_o        (mem_req_o),
        .mem_addr_o       (mem_addr_o),
        .mem_ack_i        (mem_ack_i),
        .mem_data_i       (mem_data_i)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count_o      (hit_count_o),
        .miss_count_o     (miss_count_o)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: which line address each index currently holds
    bit          model_valid [16];
    logic [27:0] model_line  [16];
    logic [31:0] last_word;
    int          exp_hits;
    int          exp_misses;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return (addr * 32'h9E37_79B1) ^ 32'h5A3C_0F96;
    endfunction

    function automatic bit model_hit(input logic [31:0] addr);
        return model_valid[addr[7:4]] && (model_line[addr[7:4]] == addr[31:4]);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 16; i++) model_valid[i] = 1'b0;
    endtask

    task automatic idle(input int n, input bit stray);
        for (int i = 0; i < n; i++) begin
            inst_cache_ren_i = 1'b0;
            inst_cache_a_i   = 32'($urandom) & ~32'h3;
            mem_ack_i        = stray ? 1'($urandom) : 1'b0;
            mem_data_i       = 32'($urandom);
            @(negedge clk);
            flush_i = 1'b0;
            check_eq("idle_stall", 32'(stall_o), 32'd0);
            check_eq("idle_req", 32'(mem_req_o), 32'd0);
            check_eq("idle_hold_data", inst_cache_d_o, last_word);
        end
        mem_ack_i = 1'b0;
    endtask

    task automatic idle_flush();
        inst_cache_ren_i = 1'b0;
        flush_i          = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        model_clear();
    endtask

    // One fetch; on a miss, also plays the backing memory with 'lat' wait cycles per word
    task automatic fetch(input logic [31:0] addr, input int lat, input bit flush_mid,
                         input bit flush_after, input bit rst_mid);
        bit          hit;
        bit          mid_done;
        int          w;
        int          wc;
        int          n;
        logic [31:0] base;
        hit              = model_hit(addr);
        inst_cache_a_i   = addr;
        inst_cache_ren_i = 1'b1;
        mem_ack_i        = 1'b0;
        @(negedge clk);
        flush_i = 1'b0;
        check_eq("lookup_stall", 32'(stall_o), 32'(!hit));
        check_eq("lookup_req", 32'(mem_req_o), 32'd0);
        if (hit) begin
            exp_hits++;
            check_eq("hit_data", inst_cache_d_o, mem_word(addr));
            last_word = mem_word(addr);
        end else begin
            exp_misses++;
            base     = {addr[31:4], 4'h0};
            w        = 0;
            wc       = 0;
            n        = 0;
            mid_done = 1'b0;
            inst_cache_ren_i = 1'($urandom);
            inst_cache_a_i   = 32'($urandom) & ~32'h3;
            while (w < 4) begin
                @(negedge clk);
                flush_i = 1'b0;
                n++;
                if (n > 200) begin
                    check_eq("refill_timeout", 32'(n), 32'd0);
                    mem_ack_i = 1'b0;
                    return;
                end
                inst_cache_ren_i = 1'($urandom);
                inst_cache_a_i   = 32'($urandom) & ~32'h3;
                check_eq("refill_stall", 32'(stall_o), 32'd1);
                check_eq("refill_req", 32'(mem_req_o), 32'd1);
                check_eq("refill_addr", mem_addr_o, base + 32'(4 * w));
                if (rst_mid && w == 2) begin
                    rst_i            = 1'b1;
                    mem_ack_i        = 1'b0;
                    inst_cache_ren_i = 1'b0;
                    #1;
                    check_eq("rst_req", 32'(mem_req_o), 32'd0);
                    check_eq("rst_stall", 32'(stall_o), 32'd0);
                    check_eq("rst_addr", mem_addr_o, 32'd0);
                    check_eq("rst_data", inst_cache_d_o, 32'd0);
                    model_clear();
                    last_word  = '0;
                    exp_hits   = 0;
                    exp_misses = 0;
                    @(negedge clk);
                    rst_i      = 1'b0;
                    mem_ack_i  = 1'b1;
                    mem_data_i = 32'($urandom);
                    @(negedge clk);
                    mem_ack_i = 1'b0;
                    check_eq("stray_ack_stall", 32'(stall_o), 32'd0);
                    check_eq("stray_ack_req", 32'(mem_req_o), 32'd0);
                    return;
                end
                if (flush_mid && w == 1 && !mid_done) begin
                    flush_i  = 1'b1;
                    mid_done = 1'b1;
                end
                if (wc == lat) begin
                    mem_ack_i  = 1'b1;
                    mem_data_i = mem_word(base + 32'(4 * w));
                    w++;
                    wc = 0;
                end else begin
                    mem_ack_i  = 1'b0;
                    mem_data_i = 32'($urandom);
                    wc++;
                end
            end
            @(negedge clk);
            flush_i   = 1'b0;
            mem_ack_i = 1'b0;
            check_eq("done_stall", 32'(stall_o), 32'd0);
            check_eq("done_req", 32'(mem_req_o), 32'd0);
            check_eq("done_data", inst_cache_d_o, mem_word(addr));
            model_valid[addr[7:4]] = 1'b1;
            model_line[addr[7:4]]  = addr[31:4];
            if (mid_done) model_clear();
            last_word = mem_word(addr);
        end
        if (flush_after) begin
            flush_i = 1'b1;
            model_clear();
        end
    endtask

    initial begin
        logic [31:0] addr;
        model_clear();
        last_word  = '0;
        exp_hits   = 0;
        exp_misses = 0;
        repeat (2) @(negedge clk);
        check_eq("reset_stall", 32'(stall_o), 32'd0);
        check_eq("reset_req", 32'(mem_req_o), 32'd0);
        check_eq("reset_addr", mem_addr_o, 32'd0);
        check_eq("reset_data", inst_cache_d_o, 32'd0);
        rst_i = 1'b0;
        idle(2, 1'b0);

        // First miss, then three hits to the same line
        fetch(32'h2000, 2, 1'b0, 1'b0, 1'b0);
        fetch(32'h2004, 2, 1'b0, 1'b0, 1'b0);
        fetch(32'h2008, 2, 1'b0, 1'b0, 1'b0);
        fetch(32'h200C, 2, 1'b0, 1'b0, 1'b0);
        // Conflicting tag on the same index
        fetch(32'h2100, 1, 1'b0, 1'b0, 1'b0);
        fetch(32'h2000, 0, 1'b0, 1'b0, 1'b0);
        idle(1, 1'b1);
        // Flush in IDLE, flush during refill, flush alongside a hit
        idle_flush();
        fetch(32'h2004, 2, 1'b0, 1'b0, 1'b0);
        fetch(32'h2008, 2, 1'b0, 1'b0, 1'b0);
        fetch(32'h2300, 1, 1'b1, 1'b0, 1'b0);
        fetch(32'h2300, 1, 1'b0, 1'b0, 1'b0);
        fetch(32'h2304, 1, 1'b0, 1'b1, 1'b0);
        fetch(32'h2304, 0, 1'b0, 1'b0, 1'b0);
        // Reset abandoned mid-refill, then miss/hit/hit/miss
        fetch(32'h2040, 1, 1'b0, 1'b0, 1'b1);
        fetch(32'h2040, 1, 1'b0, 1'b0, 1'b0);
        fetch(32'h2044, 1, 1'b0, 1'b0, 1'b0);
        fetch(32'h2048, 1, 1'b0, 1'b0, 1'b0);
        fetch(32'h2100, 1, 1'b0, 1'b0, 1'b0);
`ifdef ICACHE_STATS_EN
        check_eq("stats_hits_seq", hit_count_o, 32'd2);
        check_eq("stats_misses_seq", miss_count_o, 32'd2);
`endif
        idle(2, 1'b1);

        for (int i = 0; i < 150; i++) begin
            addr = 32'h0001_0000 + 32'($urandom_range(0, 1)) * 32'h1000
                 + 32'($urandom_range(0, 3)) * 32'd16 + 32'($urandom_range(0, 3)) * 32'd4;
            fetch(addr, int'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 14) == 0), 1'b0);
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)), 1'b1);
        end
        idle(2, 1'b0);
`ifdef ICACHE_STATS_EN
        check_eq("stats_hits_end", hit_count_o, 32'(exp_hits));
        check_eq("stats_misses_end", miss_count_o, 32'(exp_misses));
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/riscv_inst_cache.md
RISCV_INST_CACHE -- requirements
Module: riscv_inst_cache

Interface
REQ-001 Parameter: LINES, 16, number of direct-mapped lines (power of 2).
REQ-002 Parameter: WORDS, 4, 32-bit words per line (power of 2).
REQ-003 clk_i  input  1  clock; all state updates on the rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-high.
REQ-005 inst_cache_a_i  input  32  fetch address (byte address, word aligned).
REQ-006 inst_cache_ren_i  input  1  fetch read enable.
REQ-007 inst_cache_d_o  output  32  instruction word for the address captured on the previous edge.
REQ-008 stall_o  output  1  miss/refill in progress; the core holds its pipeline while high.
REQ-009 flush_i  input  1  invalidate all lines.
REQ-010 mem_req_o  output  1  backing-memory word read request.
REQ-011 mem_addr_o  output  32  backing-memory word address (byte address).
REQ-012 mem_ack_i  input  1  backing memory returns data this cycle.
REQ-013 mem_data_i  input  32  backing-memory read data, valid when mem_ack_i=1.

Function
REQ-014 Address split: offset = a[log2(WORDS)+1:2]; index = next log2(LINES) bits; tag = the remaining upper bits.
REQ-015 On each edge with ren=1 and stall_o=0: capture the address into lookup_addr and set pending=1; with ren=0: set pending=0.
REQ-016 Lookup is combinational on lookup_addr; hit = pending & valid[index] & (tag_mem[index]==tag).
REQ-017 Hit: inst_cache_d_o = data_mem[index][offset] in the same cycle, stall_o=0; latency is one cycle from address to data.
REQ-018 pending=0: inst_cache_d_o holds the last delivered word and stall_o=0.
REQ-019 FSM states: IDLE, REFILL, DONE.
REQ-020 IDLE, pending=1, miss: stall_o=1 combinationally; at the next edge go to REFILL with word counter cnt=0.
REQ-021 REFILL: mem_req_o=1 and mem_addr_o={tag,index,cnt,2'b00}, held stable until mem_ack_i=1.
REQ-022 Each ack: write mem_data_i to data_mem[index][cnt] and increment cnt. The ack on cnt=WORDS-1 writes tag_mem[index], sets valid[index] and goes to DONE.
REQ-023 A refill is always a full line starting at word 0; it does not start at the critical word.
REQ-024 DONE: stall_o=0 and inst_cache_d_o=data_mem[index][offset]; return to IDLE at the next edge. The access counts as consumed: pending is re-evaluated per REQ-015 at the same edge.
REQ-025 stall_o=1 in REFILL; mem_req_o=0 in IDLE and DONE.
REQ-026 While stall_o=1, inst_cache_a_i and inst_cache_ren_i are ignored and lookup_addr is held.
REQ-027 flush_i in IDLE: clear all valid bits at the edge; a hit evaluated in that same cycle is still served.
REQ-028 flush_i in REFILL/DONE: latched. The current refill completes and serves its word; the clear happens on entry to IDLE.
REQ-029 mem_ack_i while not in REFILL is ignored.
REQ-030 Back-to-back misses to different lines each perform a full refill; no refill overlaps another.

Reset
REQ-031 On rst_i, asynchronously: state=IDLE, all valid bits=0, pending=0, cnt=0, lookup_addr=0, flush latch=0.
REQ-032 Reset outputs: inst_cache_d_o=0, stall_o=0, mem_req_o=0, mem_addr_o=0.
REQ-033 Reset mid-refill abandons the refill. The partially written line stays invalid, and a late mem_ack_i has no effect.
REQ-034 tag_mem and data_mem are not reset.

Configuration
REQ-035 Macro ICACHE_STATS_EN defined: add outputs hit_count_o[31:0] and miss_count_o[31:0]. A counter increments once per IDLE lookup with pending=1 (hit or miss respectively) and wraps at 2^32. Both are cleared by rst_i.
REQ-036 Macro not defined: those ports and counters are absent; all other behaviour is identical.

Verification
REQ-037 Reset, then fetch 0x2000 with ren=1 -> stall_o=1 next cycle; mem_addr_o=0x2000,0x2004,0x2008,0x200C, each ack after 2 wait cycles; DONE delivers word@0x2000; stall_o=0.
REQ-038 Then fetch 0x2004, 0x2008, 0x200C on consecutive cycles -> three consecutive hits, no mem_req_o, correct words with 1-cycle latency.
REQ-039 Fetch 0x2100 (same index as 0x2000, different tag), then 0x2000 -> two full refills; 0x2000 misses again.
REQ-040 flush_i pulse in IDLE, then fetch 0x2004 -> miss and refill. flush_i asserted during a refill -> refill completes and serves its word; the next fetch to that line misses.
REQ-041 rst_i asserted at cnt=2 of a refill -> mem_req_o=0 and stall_o=0 immediately; a stray ack is ignored; a later fetch to the same line misses.
REQ-042 With ICACHE_STATS_EN: sequence miss, hit, hit, miss -> hit_count_o=2, miss_count_o=2.
